// File: rtl/data_ram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : data_ram_pkg
// Description : Shared memory constants for the data RAM. The default word
//               and address widths are held here so every user of the RAM
//               sizes its buses from the same values.
// Revision    : 1.0 - initial release
// ============================================================================
package data_ram_pkg;

  // Default data word width in bits.
  localparam int unsigned c_DW = 32;

  // Default address width in bits (word index, not byte address).
  localparam int unsigned c_AW = 8;

  // Default depth: one word per address value, so no index is ever out of range.
  localparam int unsigned c_DEPTH = 1 << c_AW;

endpackage : data_ram_pkg
`default_nettype wire

// File: rtl/data_ram.sv
`default_nettype none
// ============================================================================
// Module      : data_ram
// Description : Flat word-addressed data RAM. It has a single-port synchronous
//               write and an asynchronous (combinational) read. The
//               asynchronous active-low reset clears every word immediately
//               and forces the read data to zero while it is held.
// Revision    : 1.0 - initial release
// ============================================================================
module data_ram
  import data_ram_pkg::*;
#(
  parameter int DW    = c_DW,
  parameter int AW    = c_AW,
  parameter int DEPTH = c_DEPTH
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] addr,
  input  logic          we,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  // Storage array: one register per word, indexed directly by addr.
  logic [DW-1:0] r_mem [DEPTH];

  // Combinational read value before the reset gate.
  logic [DW-1:0] w_rd_word;

  // Reset clears all words at once without waiting for clk. Otherwise a write
  // stores the full word. wdata arrives already masked, so upper bits are
  // written as they arrive (zeros for narrow stores). Because reset is in the
  // sensitivity list, reset wins over a write edge that coincides with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (we) begin
      r_mem[addr] <= wdata;
    end
  end

  // Read mux: zero-latency lookup with no bypass. A same-address write
  // therefore shows the old word until the edge and the new word after it.
  always_comb begin
    w_rd_word = r_mem[addr];
  end

  // rdata is always driven. Holding it at zero during reset means it can
  // never expose a stale word in the same delta as the reset assertion.
  assign rdata = rst_n ? w_rd_word : '0;

endmodule : data_ram
`default_nettype wire

// File: tb/tb_data_ram.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_ram
// Description : Directed, self-checking bench for data_ram. Each scenario is
//               a task that drives stimulus and checks rdata against
//               hand-computed constants.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_ram;

  logic        clk;
  logic        rst_n;
  logic [7:0]  addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;

  int n_vec;
  int n_err;

  data_ram dut (
    .clk   (clk),
    .rst_n (rst_n),
    .addr  (addr),
    .we    (we),
    .wdata (wdata),
    .rdata (rdata)
  );

  // 10 time-unit clock; rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net so the run can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // Single write: set up on the falling edge, commit on the next rising edge.
  task automatic do_write(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    addr  = a;
    wdata = d;
    we    = 1'b1;
    @(posedge clk);
    #1;
    we = 1'b0;
  endtask

  // Put an address on the bus away from any clock edge and let it settle.
  task automatic set_addr(input logic [7:0] a);
    @(negedge clk);
    addr = a;
    #1;
  endtask

  task automatic test_reset;
    // Initial reset state.
    for (int a = 0; a < 256; a += 51) begin
      set_addr(8'(a));
      n_vec++;
      if (rdata !== 32'h0) begin
        n_err++;
        $display("FAIL init_reset addr=%02h rdata=%08h expected=00000000", a, rdata);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    // Fill some words, then assert reset mid-simulation, away from any edge.
    do_write(8'h03, 32'h01234567);
    do_write(8'h80, 32'h89ABCDEF);
    do_write(8'hFF, 32'hFFFFFFFF);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    for (int a = 0; a < 256; a++) begin
      addr = 8'(a);
      #1;
      n_vec++;
      if (rdata !== 32'h0) begin
        n_err++;
        $display("FAIL reset_sweep addr=%02h rdata=%08h expected=00000000", a, rdata);
      end
    end
    // Writes are ignored while reset is held, even with we=1.
    @(negedge clk);
    addr  = 8'h44;
    wdata = 32'hA0A0A0A0;
    we    = 1'b1;
    @(posedge clk);
    #1;
    we = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_vec++;
    if (rdata !== 32'h0) begin
      n_err++;
      $display("FAIL write_in_reset rdata=%08h expected=00000000", rdata);
    end
    // Contents stay cleared after release.
    set_addr(8'h80);
    n_vec++;
    if (rdata !== 32'h0) begin
      n_err++;
      $display("FAIL post_reset_clear rdata=%08h expected=00000000", rdata);
    end
    // The first edge with we=1 after release writes normally.
    do_write(8'h44, 32'h55AA55AA);
    n_vec++;
    if (rdata !== 32'h55AA55AA) begin
      n_err++;
      $display("FAIL first_write_after_reset rdata=%08h expected=55aa55aa", rdata);
    end
  endtask

  task automatic test_write_read;
    logic [7:0]  a_tab [4] = '{8'h05, 8'h3F, 8'h04, 8'h06};
    logic [31:0] e_tab [4] = '{32'hDEADBEEF, 32'h12345678, 32'h0, 32'h0};
    do_write(8'h05, 32'hDEADBEEF);
    do_write(8'h3F, 32'h12345678);
    for (int i = 0; i < 4; i++) begin
      set_addr(a_tab[i]);
      n_vec++;
      if (rdata !== e_tab[i]) begin
        n_err++;
        $display("FAIL write_read addr=%02h rdata=%08h expected=%08h", a_tab[i], rdata, e_tab[i]);
      end
    end
  endtask

  task automatic test_premasked_store;
    do_write(8'h10, 32'hFFFFFFFF);
    do_write(8'h10, 32'h000000AB);
    set_addr(8'h10);
    n_vec++;
    if (rdata !== 32'h000000AB) begin
      n_err++;
      $display("FAIL premasked_store rdata=%08h expected=000000ab", rdata);
    end
  endtask

  task automatic test_read_during_write;
    do_write(8'h20, 32'h11111111);
    @(negedge clk);
    addr  = 8'h20;
    wdata = 32'h22222222;
    we    = 1'b1;
    #1;
    n_vec++;
    if (rdata !== 32'h11111111) begin
      n_err++;
      $display("FAIL rdw_before_edge rdata=%08h expected=11111111", rdata);
    end
    @(posedge clk);
    #1;
    we = 1'b0;
    n_vec++;
    if (rdata !== 32'h22222222) begin
      n_err++;
      $display("FAIL rdw_after_edge rdata=%08h expected=22222222", rdata);
    end
  endtask

  task automatic test_we_low;
    do_write(8'h01, 32'hCAFEF00D);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      addr  = 8'h01;
      we    = 1'b0;
      wdata = (c % 2 == 0) ? 32'h00000000 : 32'hFFFFFFFF;
      @(posedge clk);
      #1;
      n_vec++;
      if (rdata !== 32'hCAFEF00D) begin
        n_err++;
        $display("FAIL we_low cycle=%0d rdata=%08h expected=cafef00d", c, rdata);
      end
    end
    // An unknown address with we=0 must not disturb anything.
    @(negedge clk);
    addr = 8'bxxxx_zzzz;
    @(posedge clk);
    @(posedge clk);
    set_addr(8'h01);
    n_vec++;
    if (rdata !== 32'hCAFEF00D) begin
      n_err++;
      $display("FAIL x_addr_no_corrupt rdata=%08h expected=cafef00d", rdata);
    end
  endtask

  task automatic test_boundary;
    do_write(8'hFF, 32'hA5A5A5A5);
    do_write(8'h00, 32'h5A5A5A5A);
    set_addr(8'hFF);
    n_vec++;
    if (rdata !== 32'hA5A5A5A5) begin
      n_err++;
      $display("FAIL boundary_ff rdata=%08h expected=a5a5a5a5", rdata);
    end
    set_addr(8'h00);
    n_vec++;
    if (rdata !== 32'h5A5A5A5A) begin
      n_err++;
      $display("FAIL boundary_00 rdata=%08h expected=5a5a5a5a", rdata);
    end
  endtask

  task automatic test_reset_priority;
    do_write(8'h77, 32'h13572468);
    @(negedge clk);
    addr  = 8'h77;
    wdata = 32'h9ABCDEF0;
    we    = 1'b1;
    @(posedge clk);
    rst_n = 1'b0;
    #1;
    we = 1'b0;
    n_vec++;
    if (rdata !== 32'h0) begin
      n_err++;
      $display("FAIL reset_priority_in_reset rdata=%08h expected=00000000", rdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_vec++;
    if (rdata !== 32'h0) begin
      n_err++;
      $display("FAIL reset_priority_after rdata=%08h expected=00000000", rdata);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    addr  = '0;
    we    = 1'b0;
    wdata = '0;
    test_reset();
    test_write_read();
    test_premasked_store();
    test_read_during_write();
    test_we_low();
    test_boundary();
    test_reset_priority();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_data_ram
`default_nettype wire

// File: doc/data_ram.md
DATA_RAM -- requirements
Module: data_ram

Interface
REQ-001 The block SHALL have parameter DW, default 32, meaning data word width in bits.
REQ-002 The block SHALL have parameter AW, default 8, meaning address width in bits.
REQ-003 The block SHALL have parameter DEPTH, default 256 (2**AW), meaning number of words stored.
REQ-004 Port clk, input, 1 bit: the single clock; all writes occur on its rising edge.
REQ-005 Port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 Port addr, input, AW bits: word index, not a byte address.
REQ-007 Port we, input, 1 bit: write enable, sampled on the rising edge of clk.
REQ-008 Port wdata, input, DW bits: write data, already zero-extended and masked by the caller.
REQ-009 Port rdata, output, DW bits: read data.

Function
REQ-010 Storage SHALL be DEPTH words of DW bits each, indexed directly by addr, with no byte offset and no address decoding inside the block.
REQ-011 Write: on the rising edge of clk with rst_n=1 and we=1, mem[addr] SHALL take the full DW-bit wdata.
  - No byte enables; partial-width stores arrive pre-masked, and the upper bits are written as zero.
REQ-012 With we=0, the rising edge of clk SHALL leave all contents unchanged.
REQ-013 Read SHALL be asynchronous (combinational): rdata = mem[addr].
  - Zero-cycle latency from an addr change.
  - No read enable.
REQ-014 Read-during-write to the same addr:
  - Before the clock edge, rdata SHALL show the old contents.
  - After the edge, rdata SHALL show the new data (write-first after the edge, with no bypass before it).
REQ-015 Every addr value 0..DEPTH-1 SHALL be valid.
  - No wrap-around or out-of-range case exists, because DEPTH = 2**AW.
REQ-016 Any enabling of the block by upper address bits SHALL be done by the caller through we only; rdata SHALL always be driven.
REQ-017 X or Z on addr SHALL NOT corrupt any stored word when we=0.

Reset
REQ-018 While rst_n=0, every word SHALL be cleared to 0 immediately, without waiting for a clock edge.
REQ-019 While rst_n=0, rdata SHALL read 0 for every addr.
REQ-020 While rst_n=0, writes SHALL be ignored even if we=1.
REQ-021 Reset asserted at the same time as a write edge SHALL win: the target word ends at 0.
REQ-022 After rst_n deasserts, the first rising edge of clk with we=1 SHALL perform the write normally.

Structure
REQ-023 Default widths (DW=32, AW=8) SHALL be defined as constants in the shared memory package and used as the parameter defaults.
REQ-024 The block SHALL be one flat module containing the register array, reset/write process and read mux, with no sub-module.

Verification
REQ-025 Reset: drive rst_n=0 mid-simulation after several writes, then sweep addr 0..255 -> every rdata=0x00000000.
REQ-026 Write/read: write 0xDEADBEEF to addr 0x05 and 0x12345678 to addr 0x3F -> reading 0x05 returns 0xDEADBEEF, 0x3F returns 0x12345678, and neighbours 0x04 and 0x06 remain 0.
REQ-027 Pre-masked byte store: write 0x000000AB to addr 0x10 over prior contents 0xFFFFFFFF -> rdata=0x000000AB.
REQ-028 Read-during-write: hold addr=0x20 with contents 0x11111111, apply we=1 and wdata=0x22222222 -> rdata=0x11111111 before the edge and 0x22222222 after it.
REQ-029 we=0 with toggling wdata over 10 cycles at addr 0x01 (contents 0xCAFEF00D) -> rdata stays 0xCAFEF00D.
REQ-030 Boundary and reset priority:
  - Write to addr 0xFF and addr 0x00, then read both -> each returns its own data, with no aliasing.
  - Assert rst_n low coincident with a write edge -> the word reads 0.
